alu_md: RTL
===========

ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; SHALL be at least 8 and a power of two.
REQ-002 Derived constant SHW = log2(WIDTH), shift-amount width; SHALL NOT be overridable.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 a  input  WIDTH  operand A; also the shift amount for shift ops.
REQ-006 b  input  WIDTH  operand B.
REQ-007 op  input  4  operation select.
REQ-008 start  input  1  request to launch a multiply/divide op.
REQ-009 result  output  WIDTH  combinational ALU result.
REQ-010 zero  output  1  high when result equals 0.
REQ-011 busy  output  1  multiply/divide unit occupied.
REQ-012 done  output  1  one-cycle pulse when HI/LO are updated.
REQ-013 hi, lo  output  WIDTH each  HI/LO register contents.

Function
REQ-014 Combinational ops SHALL be decoded as follows, with result depending only on a, b, op, hi and lo:
- 0000 a&b
- 0001 a|b
- 0010 a+b
- 0011 b<<a[SHW-1:0]
- 0100 arithmetic b>>>a[SHW-1:0]
- 0101 logical b>>a[SHW-1:0]
- 0110 a-b
- 0111 signed a<b zero-extended to WIDTH
REQ-015 Sums and differences SHALL wrap modulo 2^WIDTH, with no overflow flag; a[WIDTH-1:SHW] SHALL be ignored for shifts.
REQ-016 Iterative ops SHALL be 1000 MULTU, 1001 MULT (signed), 1010 DIVU and 1011 DIV (signed).
REQ-017 1100 MFHI SHALL give result=hi, 1101 MFLO SHALL give result=lo, and ops 1000-1011 and 1110-1111 SHALL give result=0.
REQ-018 zero SHALL equal (result==0), combinational, with no modelled delay.
REQ-019 The multiply/divide FSM SHALL have states IDLE and BUSY; done is a registered flag, not a state.
REQ-020 IDLE->BUSY SHALL occur on an edge with start=1 and op in 1000-1011 ("accept"); a and b are latched at accept and SHALL NOT be resampled afterwards.
REQ-021 start with any other op SHALL be ignored; start while busy=1 SHALL be ignored.
REQ-022 Cycle timing after accept at edge k:
- busy=1 from after edge k until edge k+WIDTH+1 (WIDTH iteration cycles plus 1 sign-fix cycle).
- At edge k+WIDTH+1: hi/lo written, FSM returns to IDLE, busy=0, done=1 for exactly one cycle.
REQ-023 A new accept SHALL be legal in the cycle done=1.
REQ-024 Multiply SHALL use shift-add over latched operands, giving {hi,lo} = full 2*WIDTH-bit product; MULT SHALL use magnitudes, negating the product when the operand signs differ.
REQ-025 Divide SHALL use restoring division, giving lo=quotient and hi=remainder; DIV SHALL truncate toward zero, with the remainder taking the sign of a.
REQ-026 Divide by zero (b==0) SHALL give lo=all ones and hi=a for both DIVU and DIV, with the same latency.
REQ-027 Signed overflow, DIV of MIN by -1, SHALL give lo=MIN and hi=0.
REQ-028 During BUSY, hi/lo SHALL hold their pre-accept values (MFHI/MFLO return stale data; the pipeline stalls on busy).

Reset
REQ-029 While reset=1 at an edge: FSM->IDLE, busy=0, done=0, hi=0, lo=0, and the iteration counter and latched operands SHALL be cleared.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no HI/LO write and no done pulse.
REQ-031 start coincident with reset SHALL be ignored.

Verification (WIDTH=32)
REQ-032 op=0100, a=4, b=0x80000000 -> result=0xF8000000; op=0111, a=0xFFFFFFFF, b=1 -> result=1; op=0110, a=b=5 -> zero=1.
REQ-033 start, op=1001, a=-3, b=7 at edge k -> busy=1 for 33 cycles; done=1 after edge k+33 with hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-034 start, op=1011, a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; op=1011, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 start, op=1010, a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234 after 33 busy cycles.
REQ-036 Second start 10 cycles into BUSY -> ignored, single done pulse; then reset 5 cycles into a new op -> busy=0, hi=lo=0, no done pulse.
REQ-037 Back-to-back: new start accepted in the done cycle -> busy re-asserts the next cycle, and MFLO returns the first result until the second done.

Source files
------------

// File: rtl/alu_md_if.sv
// alu_md_if -- bus between a pipeline and the alu_md execution unit.
//   a, b    : operands (a also carries the shift amount)
//   op      : 4-bit operation select
//   start   : launch request for multiply/divide ops
//   result  : combinational ALU result, zero flags result==0
//   busy    : multiply/divide unit occupied
//   done    : one-cycle pulse when hi/lo are written
//   hi, lo  : HI/LO register contents
// The master modport drives operands, the slave modport (the ALU) drives results.
interface alu_md_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             start;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output a, b, op, start,
    input  result, zero, busy, done, hi, lo
  );

  modport slave (
    input  a, b, op, start,
    output result, zero, busy, done, hi, lo
  );
endinterface

// File: rtl/alu_md.sv
// alu_md -- combinational ALU plus an iterative multiply/divide unit with
// HI/LO result registers.
//   clk    : single clock, all state on the rising edge
//   reset  : synchronous, active-high
//   bus    : alu_md_if slave (a, b, op, start in; result, zero, busy, done,
//            hi, lo out)
// Multiply is shift-add on operand magnitudes, divide is restoring division on
// magnitudes; both take WIDTH iteration cycles followed by one cycle that
// applies signs and writes HI/LO.
module alu_md #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    reset,
  alu_md_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] LAST_ITER = (SHW+1)'(WIDTH);

  if ((WIDTH < 8) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
    $error("alu_md: WIDTH must be a power of two and at least 8");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state_r;
  state_t state_nx_s;

  logic busy_s;
  logic accept_s;
  logic iter_s;
  logic fix_s;

  // Latched operation and working registers
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             div_r;
  logic             sgn_r;
  logic [WIDTH-1:0] mag_r;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_hi_r;  // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo_r;  // multiplier / dividend shifting into quotient
  logic [SHW:0]     cnt_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             done_r;

  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic [WIDTH-1:0] load_lo_s;
  logic [WIDTH-1:0] load_mag_s;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] iter_hi_s;
  logic [WIDTH-1:0] iter_lo_s;
  logic [2*WIDTH-1:0] neg_prod_s;
  logic             neg_a_s;
  logic             neg_b_s;
  logic [WIDTH-1:0] fix_hi_s;
  logic [WIDTH-1:0] fix_lo_s;
  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] result_s;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nx_s = BUSY;
        else          state_nx_s = IDLE;
      end
      BUSY: begin
        if (fix_s) state_nx_s = IDLE;
        else       state_nx_s = BUSY;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM outputs: accept only from IDLE, iterate until the count reaches WIDTH, then fix
  always_comb begin
    busy_s   = 1'b0;
    accept_s = 1'b0;
    iter_s   = 1'b0;
    fix_s    = 1'b0;
    case (state_r)
      IDLE: begin
        accept_s = bus.start && (bus.op[3:2] == 2'b10);
      end
      BUSY: begin
        busy_s = 1'b1;
        if (cnt_r == LAST_ITER) fix_s  = 1'b1;
        else                    iter_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Operand magnitudes at accept; op[1] selects divide, op[0] selects signed
  always_comb begin
    a_mag_s = bus.a;
    b_mag_s = bus.b;
    if (bus.op[0] && bus.a[WIDTH-1]) a_mag_s = {WIDTH{1'b0}} - bus.a;
    else                             a_mag_s = bus.a;
    if (bus.op[0] && bus.b[WIDTH-1]) b_mag_s = {WIDTH{1'b0}} - bus.b;
    else                             b_mag_s = bus.b;
    if (bus.op[1]) begin
      load_lo_s  = a_mag_s;
      load_mag_s = b_mag_s;
    end else begin
      load_lo_s  = b_mag_s;
      load_mag_s = a_mag_s;
    end
  end

  // One shift-add or restoring-divide step
  always_comb begin
    add_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, mag_r} : {(WIDTH+1){1'b0}});
    trial_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
    diff_s  = trial_s - {1'b0, mag_r};
    if (div_r) begin
      // Borrow out of the trial subtraction means restore (keep the shifted remainder)
      if (diff_s[WIDTH]) iter_hi_s = trial_s[WIDTH-1:0];
      else               iter_hi_s = diff_s[WIDTH-1:0];
      iter_lo_s = {acc_lo_r[WIDTH-2:0], ~diff_s[WIDTH]};
    end else begin
      iter_hi_s = add_s[WIDTH:1];
      iter_lo_s = {add_s[0], acc_lo_r[WIDTH-1:1]};
    end
  end

  // Sign fix-up and divide special cases for the final cycle
  always_comb begin
    neg_a_s    = sgn_r & a_r[WIDTH-1];
    neg_b_s    = sgn_r & b_r[WIDTH-1];
    neg_prod_s = {(2*WIDTH){1'b0}} - {acc_hi_r, acc_lo_r};
    fix_hi_s   = acc_hi_r;
    fix_lo_s   = acc_lo_r;
    if (!div_r) begin
      if (neg_a_s ^ neg_b_s) {fix_hi_s, fix_lo_s} = neg_prod_s;
      else                   {fix_hi_s, fix_lo_s} = {acc_hi_r, acc_lo_r};
    end else if (b_r == {WIDTH{1'b0}}) begin
      fix_lo_s = {WIDTH{1'b1}};
      fix_hi_s = a_r;
    end else begin
      // MIN / -1 falls out naturally: quotient magnitude 2^(W-1) negates to MIN
      if (neg_a_s ^ neg_b_s) fix_lo_s = {WIDTH{1'b0}} - acc_lo_r;
      else                   fix_lo_s = acc_lo_r;
      if (neg_a_s) fix_hi_s = {WIDTH{1'b0}} - acc_hi_r;
      else         fix_hi_s = acc_hi_r;
    end
  end

  // Multiply/divide datapath registers and HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      div_r    <= 1'b0;
      sgn_r    <= 1'b0;
      mag_r    <= {WIDTH{1'b0}};
      acc_hi_r <= {WIDTH{1'b0}};
      acc_lo_r <= {WIDTH{1'b0}};
      cnt_r    <= {(SHW+1){1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      done_r   <= 1'b0;
    end else begin
      done_r <= fix_s;
      if (accept_s) begin
        a_r      <= bus.a;
        b_r      <= bus.b;
        div_r    <= bus.op[1];
        sgn_r    <= bus.op[0];
        mag_r    <= load_mag_s;
        acc_hi_r <= {WIDTH{1'b0}};
        acc_lo_r <= load_lo_s;
        cnt_r    <= {(SHW+1){1'b0}};
      end else if (iter_s) begin
        acc_hi_r <= iter_hi_s;
        acc_lo_r <= iter_lo_s;
        cnt_r    <= cnt_r + {{SHW{1'b0}}, 1'b1};
      end else if (fix_s) begin
        hi_r <= fix_hi_s;
        lo_r <= fix_lo_s;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign shamt_s = bus.a[SHW-1:0];

  // Combinational ALU result decode
  always_comb begin
    result_s = {WIDTH{1'b0}};
    case (bus.op)
      4'b0000: result_s = bus.a & bus.b;
      4'b0001: result_s = bus.a | bus.b;
      4'b0010: result_s = bus.a + bus.b;
      4'b0011: result_s = bus.b << shamt_s;
      4'b0100: result_s = $unsigned($signed(bus.b) >>> shamt_s);
      4'b0101: result_s = bus.b >> shamt_s;
      4'b0110: result_s = bus.a - bus.b;
      4'b0111: result_s = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      4'b1100: result_s = hi_r;
      4'b1101: result_s = lo_r;
      default: result_s = {WIDTH{1'b0}};
    endcase
  end

  assign bus.result = result_s;
  assign bus.zero   = (result_s == {WIDTH{1'b0}});
  assign bus.busy   = busy_s;
  assign bus.done   = done_r;
  assign bus.hi     = hi_r;
  assign bus.lo     = lo_r;
endmodule
